// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] d;
    logic             shift_en;
    logic             serial_out;
    logic             serial_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, d, shift_en,
        input  load_ready, serial_out, serial_valid, busy, done
    );

    modport slave (
        input  load_valid, d, shift_en,
        output load_ready, serial_out, serial_valid, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: captures a word on a valid/ready handshake and
// shifts it out one bit per enabled clock, with a valid strobe and end-of-word done pulse.
module piso_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input logic               clk_i,
    input logic               rst_ni,
    piso_serializer_if.slave  bus_io
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;
    logic             done_q, done_d;
    logic             load_ready;

    assign load_ready          = (state_q == StIdle) && rst_ni;
    assign bus_io.load_ready   = load_ready;
    assign bus_io.busy         = (state_q == StShift);
    assign bus_io.serial_out   = serial_out_q;
    assign bus_io.serial_valid = serial_valid_q;
    assign bus_io.done         = done_q;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        cnt_d          = cnt_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        done_d         = 1'b0;
        unique case (state_q)
            StIdle: begin
                serial_out_d   = IDLE_LEVEL;
                serial_valid_d = 1'b0;
                if (bus_io.load_valid && load_ready) begin
                    state_d        = StShift;
                    shreg_d        = bus_io.d;
                    cnt_d          = '0;
                    serial_out_d   = MSB_FIRST ? bus_io.d[WIDTH-1] : bus_io.d[0];
                    serial_valid_d = 1'b1;
                end
            end
            StShift: begin
                if (bus_io.shift_en) begin
                    if (cnt_q == LastCnt) begin
                        state_d        = StIdle;
                        serial_out_d   = IDLE_LEVEL;
                        serial_valid_d = 1'b0;
                        done_d         = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                        // The bit adjacent to the output end becomes the next serial bit.
                        if (MSB_FIRST) begin
                            shreg_d      = {shreg_q[WIDTH-2:0], 1'b0};
                            serial_out_d = shreg_q[WIDTH-2];
                        end else begin
                            shreg_d      = {1'b0, shreg_q[WIDTH-1:1]};
                            serial_out_d = shreg_q[1];
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            shreg_q        <= '0;
            cnt_q          <= '0;
            serial_out_q   <= IDLE_LEVEL;
            serial_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shreg_q        <= shreg_d;
            cnt_q          <= cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            done_q         <= done_d;
        end
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out transmitter. It captures a WIDTH-bit word through a valid/ready load handshake and shifts the word out one bit per enabled clock.
- It is the serial-side counterpart of the team's parallel enable-register blocks. It drives a downstream serial receiver with a qualifying valid strobe and an end-of-word done pulse.

Parameters:
- WIDTH, 4, word width in bits; WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on serial_out whenever serial_valid = 0.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; 0 = reset.
- load_valid  input  1  upstream word available on d.
- load_ready  output  1  block can accept a word this cycle.
- d  input  WIDTH  parallel word; sampled only on load handshake.
- shift_en  input  1  advance to next bit; 0 = hold current bit.
- serial_out  output  1  current serial bit (registered).
- serial_valid  output  1  serial_out carries a data bit (registered).
- busy  output  1  a word is being shifted (state == SHIFT).
- done  output  1  one-cycle pulse after the last bit (registered).

Behaviour:
- Reset: clk is the only clock. reset is synchronous and active-low; it is sampled on the rising edge of clk, and reset == 0 at an edge forces the following register values:
  - state = IDLE, shift register = 0, bit_cnt = 0.
  - serial_out = IDLE_LEVEL, serial_valid = 0, done = 0.
- Reset has priority over every other input.
- load_ready = (state == IDLE) && reset. It is combinational and is forced 0 while reset is low.
- busy = (state == SHIFT). It is combinational.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with load_valid && load_ready, capture d into the shift register and clear bit_cnt to 0.
  - Go to SHIFT, with serial_out = first bit (d[WIDTH-1] if MSB_FIRST, else d[0]) and serial_valid = 1.
  - Otherwise remain in IDLE, with serial_out = IDLE_LEVEL and serial_valid = 0.
- SHIFT, edge with shift_en = 0: hold serial_out, bit_cnt and the shift register. Each bit is therefore presented for at least one cycle.
- SHIFT, edge with shift_en = 1 and bit_cnt < WIDTH-1:
  - Shift the register toward the output end.
  - Increment bit_cnt.
  - serial_out = next bit.
- SHIFT, edge with shift_en = 1 and bit_cnt == WIDTH-1:
  - Go to IDLE.
  - serial_valid = 0, serial_out = IDLE_LEVEL.
  - done = 1 for exactly one cycle.
- done is 0 in every other cycle.
- Latency: the first bit appears on serial_out in the cycle after the load handshake. With shift_en held at 1, a word occupies exactly WIDTH cycles of serial_valid, and done follows in the next cycle.
- Back-to-back: the done cycle is an IDLE cycle with load_ready = 1. A load accepted in that cycle starts the next word in the following cycle, so the minimum inter-word gap is one cycle.
- load_valid in SHIFT is ignored; load_ready = 0 there. d is not sampled outside the handshake, so changing d mid-word has no effect.
- shift_en in IDLE is ignored.
- bit_cnt width is $clog2(WIDTH). No wrap-around occurs: bit_cnt never exceeds WIDTH-1.
- Reset mid-word: the word is aborted with no done pulse. Outputs take their reset values in the cycle after the reset edge.

Test Plan:
- Reset: hold reset = 0 for 2 cycles, then release -> serial_out = 0, serial_valid = 0, done = 0, busy = 0; load_ready = 0 during reset and 1 after release.
- Basic word, WIDTH = 4, MSB_FIRST = 1, shift_en = 1: load d = 4'b1010 -> serial_out 1,0,1,0 over 4 cycles with serial_valid = 1 and busy = 1; done = 1 in cycle 5; load_ready = 1 again in cycle 5.
- Stall: load 4'b0101 and drop shift_en for 2 cycles after the first bit -> the first bit (0) is held 3 cycles; sequence 0,1,0,1; serial_valid is high for 6 cycles; one done pulse.
- Ignored load: during a 4'b1010 transfer, assert load_valid with d = 4'b1111 -> load_ready = 0; output stays 1,0,1,0; no second word starts.
- Reset mid-word: pull reset low after the second bit of 4'b1100 -> the next cycle shows serial_valid = 0, serial_out = IDLE_LEVEL; no done pulse; the new load after release starts cleanly.
- LSB-first and back-to-back, MSB_FIRST = 0: load 4'b0011, then assert load_valid with d = 4'b1000 during the done cycle -> output 1,1,0,0, one gap cycle, then 0,0,0,1; two done pulses.
